ff_sync: RTL and testbench



---
 rtl/ff_sync_pkg.sv | 13 +
 rtl/ff_sync_bit.sv | 79 +++++++
 rtl/ff_sync.sv | 33 +++
 tb/tb_ff_sync.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ff_sync_pkg.sv
// Shared defaults and sizing helper for the ff_sync input synchroniser.
package ff_sync_pkg;

    localparam int unsigned WIDTH_DEF       = 1;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned FILTER_LEN_DEF  = 1;

    // Counter must be able to hold FILTER_LEN-1 without wrapping.
    function automatic int unsigned cnt_w(input int unsigned filter_len);
        return (filter_len < 1) ? 1 : $clog2(filter_len + 1);
    endfunction

endpackage

// File: rtl/ff_sync_bit.sv
// One bit of the synchroniser: flop chain, persistence filter and edge pulses.
module ff_sync_bit
    import ff_sync_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned FILTER_LEN  = FILTER_LEN_DEF,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic data_i,
    output logic data_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned     CW       = cnt_w(FILTER_LEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_LEN - 1);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("ff_sync_bit: SYNC_STAGES must be >= 2");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter
        $error("ff_sync_bit: FILTER_LEN must be >= 1");
    end

    (* ASYNC_REG = "TRUE", dont_touch = "TRUE" *)
    logic [SYNC_STAGES-1:0] sync_q;

    logic          synced;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          data_q, data_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    // Pure shift register: nothing but flops between stages.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], data_i};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        data_d = data_q;
        cnt_d  = '0;
        if (synced != data_q) begin
            if (cnt_q == CNT_LAST) begin
                data_d = synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise_d = data_d & ~data_q;
        fall_d = ~data_d & data_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            data_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign data_o = data_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/ff_sync.sv
// Multi-bit asynchronous input synchroniser; every bit is an independent ff_sync_bit.
module ff_sync
    import ff_sync_pkg::*;
#(
    parameter int unsigned      WIDTH       = WIDTH_DEF,
    parameter int unsigned      SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned      FILTER_LEN  = FILTER_LEN_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ff_sync_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN),
            .RESET_VAL   (RESET_VAL[i])
        ) u_bit (
            .clk_i  (i_clock),
            .rst_ni (i_reset_n),
            .data_i (i_data[i]),
            .data_o (o_data[i]),
            .rise_o (o_rise[i]),
            .fall_o (o_fall[i])
        );
    end

endmodule

// File: tb/tb_ff_sync.sv
// Directed checks of ff_sync in four parameterisations sharing one clock and reset.
module tb_ff_sync;

    logic clk = 1'b0;
    logic clk10 = 1'b0;
    logic rst_n = 1'b0;
    logic rnd_en = 1'b0;

    logic       a_data = 1'b0, a_q, a_r, a_f;   // defaults
    logic       b_data = 1'b0, b_q, b_r, b_f;   // FILTER_LEN=3
    logic [3:0] c_data = 4'h0, c_q, c_r, c_f;   // WIDTH=4, RESET_VAL=1111
    logic       d_data = 1'b0, d_q, d_r, d_f;   // SYNC_STAGES=3

    int n_cmp = 0;
    int n_err = 0;

    always #35 clk = ~clk;
    always #50 clk10 = ~clk10;

    always @(posedge clk10) if (rnd_en) a_data = 1'($urandom);

    ff_sync u_a (.i_clock(clk), .i_reset_n(rst_n), .i_data(a_data),
                 .o_data(a_q), .o_rise(a_r), .o_fall(a_f));
    ff_sync #(.FILTER_LEN(3)) u_b (.i_clock(clk), .i_reset_n(rst_n), .i_data(b_data),
                 .o_data(b_q), .o_rise(b_r), .o_fall(b_f));
    ff_sync #(.WIDTH(4), .RESET_VAL(4'hF)) u_c (.i_clock(clk), .i_reset_n(rst_n), .i_data(c_data),
                 .o_data(c_q), .o_rise(c_r), .o_fall(c_f));
    ff_sync #(.SYNC_STAGES(3)) u_d (.i_clock(clk), .i_reset_n(rst_n), .i_data(d_data),
                 .o_data(d_q), .o_rise(d_r), .o_fall(d_f));

    task automatic tick();
        @(posedge clk);
        #10;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        a_data = 1'b1;
        rst_n = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            tick();
            n_cmp++;
            if ({a_q, a_r, a_f} !== 3'b000) begin
                n_err++;
                $display("FAIL reset_hold t=%0d: got q/r/f=%b expected 000", t, {a_q, a_r, a_f});
            end
        end
        rst_n = 1'b1;
        // Get the chain full of 1s but o_data not yet updated, then reset.
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({a_q, a_r, a_f} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_mid: got q/r/f=%b expected 000", {a_q, a_r, a_f});
        end
        a_data = 1'b0;
        rst_n = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            tick();
            n_cmp++;
            if ({a_q, a_r, a_f} !== 3'b000) begin
                n_err++;
                $display("FAIL reset_flush t=%0d: got q/r/f=%b expected 000", t, {a_q, a_r, a_f});
            end
        end
    endtask

    task automatic test_edges();
        logic eq, er, ef;
        a_data = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            tick();
            eq = (t >= 3);
            er = (t == 3);
            n_cmp++;
            if ({a_q, a_r, a_f} !== {eq, er, 1'b0}) begin
                n_err++;
                $display("FAIL rise t=%0d: got q/r/f=%b expected %b", t, {a_q, a_r, a_f}, {eq, er, 1'b0});
            end
        end
        a_data = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            tick();
            eq = (t < 3);
            ef = (t == 3);
            n_cmp++;
            if ({a_q, a_r, a_f} !== {eq, 1'b0, ef}) begin
                n_err++;
                $display("FAIL fall t=%0d: got q/r/f=%b expected %b", t, {a_q, a_r, a_f}, {eq, 1'b0, ef});
            end
        end
    endtask

    task automatic test_filter();
        logic [7:0] exp_q, exp_r, exp_f;
        // Two captured cycles: rejected.
        b_data = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t == 2) b_data = 1'b0;
            n_cmp++;
            if ({b_q, b_r, b_f} !== 3'b000) begin
                n_err++;
                $display("FAIL filter_short t=%0d: got q/r/f=%b expected 000", t, {b_q, b_r, b_f});
            end
        end
        // Three captured cycles: accepted at edge k+4, released at k+7.
        exp_q = 8'b0111_0000;
        exp_r = 8'b0001_0000;
        exp_f = 8'b1000_0000;
        b_data = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t == 3) b_data = 1'b0;
            n_cmp++;
            if ({b_q, b_r, b_f} !== {exp_q[t-1], exp_r[t-1], exp_f[t-1]}) begin
                n_err++;
                $display("FAIL filter_long t=%0d: got q/r/f=%b expected %b", t, {b_q, b_r, b_f},
                         {exp_q[t-1], exp_r[t-1], exp_f[t-1]});
            end
        end
    endtask

    task automatic test_reset_val();
        logic [3:0] eq, ef;
        c_data = 4'h0;
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({c_q, c_r, c_f} !== {4'hF, 4'h0, 4'h0}) begin
            n_err++;
            $display("FAIL resetval_reset: got q=%h r=%h f=%h expected q=f r=0 f=0", c_q, c_r, c_f);
        end
        c_data = 4'b0101;
        rst_n = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            tick();
            eq = (t >= 3) ? 4'b0101 : 4'b1111;
            ef = (t == 3) ? 4'b1010 : 4'b0000;
            n_cmp++;
            if ({c_q, c_r, c_f} !== {eq, 4'h0, ef}) begin
                n_err++;
                $display("FAIL resetval t=%0d: got q=%h r=%h f=%h expected q=%h r=0 f=%h",
                         t, c_q, c_r, c_f, eq, ef);
            end
        end
    endtask

    task automatic test_stages3();
        logic eq, er;
        d_data = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            tick();
            eq = (t >= 4);
            er = (t == 4);
            n_cmp++;
            if ({d_q, d_r, d_f} !== {eq, er, 1'b0}) begin
                n_err++;
                $display("FAIL stages3 t=%0d: got q/r/f=%b expected %b", t, {d_q, d_r, d_f}, {eq, er, 1'b0});
            end
        end
    endtask

    task automatic test_random();
        logic hist [0:47];
        logic eq, ep;
        rnd_en = 1'b1;
        for (int n = 0; n < 48; n++) begin
            @(posedge clk);
            hist[n] = a_data;
            #10;
            if (n >= 4) begin
                eq = hist[n-2];
                ep = hist[n-3];
                n_cmp++;
                if ($isunknown({a_q, a_r, a_f}) || {a_q, a_r, a_f} !== {eq, eq & ~ep, ~eq & ep}) begin
                    n_err++;
                    $display("FAIL random n=%0d: got q/r/f=%b expected %b", n, {a_q, a_r, a_f},
                             {eq, eq & ~ep, ~eq & ep});
                end
            end
        end
        rnd_en = 1'b0;
    endtask

    initial begin
        do_reset();
        test_reset();
        test_edges();
        test_filter();
        test_reset_val();
        test_stages3();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
